// File: rtl/prog_loader.sv
// Streams a program image into the core's instruction cache over a valid/ready port,
// then pulses loadPC with the entry PC. Tracks overflow, abort and a running checksum.
module prog_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 7,
    parameter int PC_W   = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [PC_W-1:0]   entry_pc,
    input  logic              in_valid,
    input  logic [N-1:0]      in_word,
    output logic              in_ready,
    output logic              prog,
    output logic              prog_we,
    output logic [ADDR_W-1:0] blockAddr,
    output logic [N-1:0]      Iword,
    output logic              loadPC,
    output logic [PC_W-1:0]   initPC,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [N-1:0]      checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_RUN
    } state_t;

    localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(1) << ADDR_W;

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     acc_cnt;
    logic [ADDR_W:0]     cnt_reg;
    logic [PC_W-1:0]     entry_reg;
    logic [ADDR_W+1:0]   end_addr;
    logic                accept;

    // Widened by one bit so base+count == depth is representable and legal.
    assign end_addr = {2'b00, base_addr} + {1'b0, word_count};
    assign accept   = in_valid & in_ready & ~abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            acc_cnt   <= '0;
            cnt_reg   <= '0;
            entry_reg <= '0;
            in_ready  <= 1'b0;
            prog      <= 1'b0;
            prog_we   <= 1'b0;
            blockAddr <= '0;
            Iword     <= '0;
            loadPC    <= 1'b0;
            initPC    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
        end else begin
            prog_we <= 1'b0;
            loadPC  <= 1'b0;
            case (state)
                S_IDLE, S_RUN: begin
                    if (start) begin
                        done <= 1'b0;
                        if (end_addr > DEPTH) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            err       <= 1'b0;
                            checksum  <= '0;
                            cnt_reg   <= word_count;
                            wr_ptr    <= base_addr;
                            acc_cnt   <= '0;
                            entry_reg <= entry_pc;
                            busy      <= 1'b1;
                            if (word_count != '0) begin
                                state    <= S_LOAD;
                                prog     <= 1'b1;
                                in_ready <= 1'b1;
                            end else begin
                                state  <= S_LAUNCH;
                                loadPC <= 1'b1;
                                initPC <= entry_pc;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        err      <= 1'b1;
                        state    <= S_IDLE;
                        prog     <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                    end else if (accept) begin
                        blockAddr <= wr_ptr;
                        Iword     <= in_word;
                        prog_we   <= 1'b1;
                        wr_ptr    <= wr_ptr + ADDR_W'(1);
                        acc_cnt   <= acc_cnt + (ADDR_W+1)'(1);
                        checksum  <= checksum + in_word;
                        in_ready  <= (acc_cnt + (ADDR_W+1)'(1)) < cnt_reg;
                    end else if (acc_cnt == cnt_reg) begin
                        // Reached only once the final write cycle has been presented.
                        state  <= S_LAUNCH;
                        prog   <= 1'b0;
                        loadPC <= 1'b1;
                        initPC <= entry_reg;
                    end
                end
                S_LAUNCH: begin
                    state <= S_RUN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a reference cache image and write list are built
// from the load parameters and compared with what the loader actually wrote.
module tb_prog_loader;
    localparam int N     = 32;
    localparam int AW    = 7;
    localparam int PW    = 30;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic [PW-1:0] entry_pc = '0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_word = '0;
    logic          in_ready, prog, prog_we, loadPC, busy, done, err;
    logic [AW-1:0] blockAddr;
    logic [N-1:0]  Iword, checksum;
    logic [PW-1:0] initPC;

    prog_loader #(.N(N), .ADDR_W(AW), .PC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count), .entry_pc(entry_pc),
        .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
        .prog(prog), .prog_we(prog_we), .blockAddr(blockAddr), .Iword(Iword),
        .loadPC(loadPC), .initPC(initPC), .busy(busy), .done(done),
        .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed side: cache image and write sequence seen on the core port.
    logic [N-1:0]  obs_mem [DEPTH];
    logic [N-1:0]  ref_mem [DEPTH];
    int            wr_addr_q[$];
    logic [N-1:0]  wr_data_q[$];
    int            lpc_cnt, lpc_cyc, we_noprog;
    logic [PW-1:0] lpc_val;
    bit            prog_seen;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prog_we) begin
                obs_mem[blockAddr] = Iword;
                wr_addr_q.push_back(int'(blockAddr));
                wr_data_q.push_back(Iword);
                if (!prog) we_noprog++;
            end
            if (loadPC) begin
                lpc_cnt++;
                lpc_cyc = cyc;
                lpc_val = initPC;
            end
            if (prog) prog_seen = 1'b1;
        end
    end

    logic [N-1:0] img [5] = '{32'h00300093, 32'h00400113, 32'h002081B3,
                              32'h00302023, 32'h00002203};

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        lpc_cnt   = 0;
        lpc_cyc   = -1;
        we_noprog = 0;
        prog_seen = 1'b0;
    endtask

    task automatic compare_mem(input string tag);
        int diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (obs_mem[i] !== ref_mem[i]) diffs++;
        check({tag, "_mem"}, diffs, 0);
    endtask

    // One load through the valid/ready port; abort_at < 0 means no abort.
    task automatic run_load(input string tag, input int base, input int cnt,
                            input logic [PW-1:0] entry, input int gap_pct,
                            input int abort_at, input bit use_img);
        logic [N-1:0] words[$];
        logic [N-1:0] sum = '0;
        int start_cyc, idx, guard, n_wr, seq_bad;
        bit aborted = 1'b0;
        for (int i = 0; i < cnt; i++)
            words.push_back(use_img ? img[i % 5] : $urandom);
        clear_mon();
        @(negedge clk);
        start      = 1'b1;
        base_addr  = base[AW-1:0];
        word_count = cnt[AW:0];
        entry_pc   = entry;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
        if (base + cnt > DEPTH) begin
            repeat (3) @(negedge clk);
            check({tag, "_ovf_err"}, err, 1);
            check({tag, "_ovf_busy"}, busy, 0);
            check({tag, "_ovf_prog"}, prog_seen, 0);
            check({tag, "_ovf_writes"}, wr_addr_q.size(), 0);
            compare_mem(tag);
            return;
        end
        idx = 0;
        guard = 0;
        while (idx < cnt && !aborted && guard < 2000) begin
            if (idx == abort_at) begin
                abort    = 1'b1;
                in_valid = 1'b1;
                in_word  = $urandom;
                @(negedge clk);
                abort    = 1'b0;
                in_valid = 1'b0;
                aborted  = 1'b1;
            end else begin
                in_valid = ($urandom_range(99) >= gap_pct);
                in_word  = words[idx];
                if (in_valid && in_ready) idx++;
                @(negedge clk);
                in_valid = 1'b0;
                guard++;
            end
        end
        if (guard >= 2000) check({tag, "_feed_timeout"}, 0, 1);
        n_wr = aborted ? abort_at : cnt;
        for (int i = 0; i < n_wr; i++) begin
            ref_mem[(base + i) % DEPTH] = words[i];
            sum += words[i];
        end
        if (aborted) begin
            repeat (2) @(negedge clk);
            check({tag, "_abort_err"}, err, 1);
            check({tag, "_abort_busy"}, busy, 0);
            check({tag, "_abort_prog"}, prog, 0);
            check({tag, "_abort_loadpc"}, lpc_cnt, 0);
        end else begin
            guard = 0;
            while (!done && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            check({tag, "_done"}, done, 1);
            check({tag, "_err"}, err, 0);
            check({tag, "_busy"}, busy, 0);
            check({tag, "_loadpc_pulses"}, lpc_cnt, 1);
            check({tag, "_loadpc_pc"}, lpc_val, entry);
            check({tag, "_initpc_hold"}, initPC, entry);
            check({tag, "_prog_seen"}, prog_seen, cnt != 0);
            if (gap_pct == 0)
                check({tag, "_latency"}, lpc_cyc, start_cyc + ((cnt == 0) ? 0 : cnt + 1));
        end
        check({tag, "_nwrites"}, wr_addr_q.size(), n_wr);
        seq_bad = 0;
        for (int i = 0; i < n_wr && i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != (base + i) % DEPTH || wr_data_q[i] !== words[i]) seq_bad++;
        check({tag, "_wr_seq"}, seq_bad, 0);
        check({tag, "_we_without_prog"}, we_noprog, 0);
        check({tag, "_checksum"}, checksum, sum);
        compare_mem(tag);
        $display("load %s base=%0d count=%0d writes=%0d err=%0d checksum=%08h",
                 tag, base, cnt, wr_addr_q.size(), err, checksum);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            obs_mem[i] = '0;
            ref_mem[i] = '0;
        end
        clear_mon();
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", |{in_ready, prog, prog_we, blockAddr, Iword, loadPC,
                                 initPC, busy, done, err, checksum}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_load("image5", 0, 5, '0, 0, -1, 1'b1);
        run_load("top_edge", 124, 4, 30'h55, 0, -1, 1'b0);
        run_load("overflow", 125, 4, 30'h66, 0, -1, 1'b0);
        run_load("zero_cnt", 3, 0, 30'h10, 0, -1, 1'b0);
        run_load("gaps8", 40, 8, 30'h123, 50, -1, 1'b0);
        run_load("abort3", 60, 8, 30'h7, 0, 3, 1'b0);
        run_load("reload", 60, 8, 30'h8, 0, -1, 1'b0);

        // Asynchronous reset between edges in the middle of a load.
        clear_mon();
        @(negedge clk);
        start = 1'b1; base_addr = 7'd90; word_count = 8'd6; entry_pc = 30'h9;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_word  = 32'hA000_0000 + i;
            ref_mem[90 + i] = in_word;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midload_reset_outputs", |{in_ready, prog, prog_we, blockAddr, Iword, loadPC,
                                         initPC, busy, done, err, checksum}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {busy, prog, in_ready, done}, 0);
        compare_mem("midload_reset");
        $display("reset mid-load writes_before_reset=%0d", wr_addr_q.size());

        for (int t = 0; t < 5; t++) begin
            int c = $urandom_range(1, 20);
            run_load($sformatf("rand%0d", t), $urandom_range(0, DEPTH - c), c,
                     PW'($urandom), 40, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
